// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align -- load/store alignment unit between the MEM stage and datamem.
//
// Turns RV32 byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into datamem
// word accesses: byte strobes, lane-shifted store data and extended load data.
// datamem reads are synchronous, so load data is formed the cycle after the
// word address is presented.
//
// Build option: define MISALIGNED_EN to split word-crossing accesses into two
// back-to-back datamem cycles (with stall). Without it, any access that is not
// naturally aligned is dropped and flagged on misalign one cycle later.
//
// Ports:
//   clk, nrst                  clock (rising edge), async active-low reset
//   req_valid/we/funct3/addr/wdata   MEM-stage request (addr[11:0] used)
//   stall                      hold the request for one more cycle
//   rsp_valid, rsp_rdata       load result pulse (rdata is 0 when not valid)
//   misalign                   misaligned-access fault pulse
//   dm_write, data_addr, data_in, data_out   datamem port
// ----------------------------------------------------------------------------
module lsu_align (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign,
   output logic [3:0]  dm_write,
   output logic [9:0]  data_addr,
   output logic [31:0] data_in,
   input  logic [31:0] data_out
);

   // Byte lanes touched by an access of the given size, before shifting.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   // Legal load/store encodings; anything else is silently dropped.
   function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
      case ({we, f3})
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101: funct3_ok = 1'b1;
         4'b1000, 4'b1001, 4'b1010:                   funct3_ok = 1'b1;
         default:                                     funct3_ok = 1'b0;
      endcase
   endfunction

   // Select byte/half/word from the right-aligned word and extend it.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  load_extend = {{24{w[7]}}, w[7:0]};
         3'b001:  load_extend = {{16{w[15]}}, w[15:0]};
         3'b010:  load_extend = w;
         3'b100:  load_extend = {24'h000000, w[7:0]};
         3'b101:  load_extend = {16'h0000, w[15:0]};
         default: load_extend = 32'h0000_0000;
      endcase
   endfunction

   logic [1:0]  off_s;
   logic [9:0]  wa_s;
   logic [3:0]  mask_s;
   logic        idle_s;
   logic        go_s;
   logic        ok_s;
   logic        split_s;
   logic [3:0]  lane_mask_s;
   logic [31:0] lane_data_s;
   logic [31:0] rsp_word_s;
   logic        unused_s;

   logic        pend_r;
   logic [1:0]  off_r;
   logic [2:0]  f3_r;

   assign off_s    = req_addr[1:0];
   assign wa_s     = req_addr[11:2];
   assign mask_s   = size_mask(req_funct3[1:0]);
   assign go_s     = req_valid && idle_s && funct3_ok(req_we, req_funct3);
   assign unused_s = ^req_addr[31:12];

`ifdef MISALIGNED_EN
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] SECOND = 1'b1;

   logic [0:0]  state_r;
   logic [9:0]  wa_r;
   logic        we_r;
   logic [3:0]  hi_mask_r;
   logic [31:0] hi_data_r;
   logic        two_r;
   logic [31:0] word1_r;
   logic [7:0]  mask8_s;
   logic [63:0] data64_s;

   // Shifting into 8 lanes / 64 bits puts the spill-over into the next word
   // in the upper half, which is exactly what the second access writes.
   assign mask8_s     = {4'b0000, mask_s} << off_s;
   assign data64_s    = {32'h0000_0000, req_wdata} << {off_s, 3'b000};
   assign lane_mask_s = mask8_s[3:0];
   assign lane_data_s = data64_s[31:0];
   assign idle_s      = (state_r == IDLE);
   assign ok_s        = go_s;
   assign split_s     = go_s && (mask8_s[7:4] != 4'b0000);
   assign misalign    = 1'b0;
   assign rsp_word_s  = 32'({(two_r ? data_out : 32'h0000_0000),
                             (two_r ? word1_r  : data_out)} >> {off_r, 3'b000});
`else
   logic aligned_s;
   logic bad_s;
   logic misalign_r;

   // Natural alignment check: halves on even bytes, words on word boundaries.
   always_comb begin
      case (req_funct3[1:0])
         2'b00:   aligned_s = 1'b1;
         2'b01:   aligned_s = ~off_s[0];
         2'b10:   aligned_s = (off_s == 2'b00);
         default: aligned_s = 1'b0;
      endcase
   end

   assign lane_mask_s = mask_s << off_s;
   assign lane_data_s = req_wdata << {off_s, 3'b000};
   assign idle_s      = 1'b1;
   assign ok_s        = go_s && aligned_s;
   assign bad_s       = go_s && !aligned_s;
   assign split_s     = 1'b0;
   assign misalign    = misalign_r;
   assign rsp_word_s  = data_out >> {off_r, 3'b000};
`endif

   assign rsp_valid = pend_r;

   // Load result: zero whenever no response is being presented.
   always_comb begin
      rsp_rdata = 32'h0000_0000;
      if (pend_r) begin
         rsp_rdata = load_extend(f3_r, rsp_word_s);
      end else begin
         rsp_rdata = 32'h0000_0000;
      end
   end

   // datamem port drive; reset kills any write in flight immediately.
   always_comb begin
      dm_write  = 4'b0000;
      data_addr = 10'd0;
      data_in   = 32'h0000_0000;
      stall     = 1'b0;
      if (!nrst) begin
         dm_write = 4'b0000;
      end
`ifdef MISALIGNED_EN
      else if (state_r == SECOND) begin
         // Word address wraps naturally in 10 bits (0x3FF + 1 = 0x000).
         data_addr = wa_r + 10'd1;
         if (we_r) begin
            dm_write = hi_mask_r;
            data_in  = hi_data_r;
         end else begin
            dm_write = 4'b0000;
         end
      end
`endif
      else if (req_valid) begin
         data_addr = wa_s;
         stall     = split_s;
         if (ok_s && req_we) begin
            dm_write = lane_mask_s;
            data_in  = lane_data_s;
         end else begin
            dm_write = 4'b0000;
         end
      end else begin
         stall = 1'b0;
      end
   end

   // Request latching, load-pending tracking and split sequencing.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pend_r     <= 1'b0;
         off_r      <= 2'b00;
         f3_r       <= 3'b000;
`ifdef MISALIGNED_EN
         state_r    <= IDLE;
         wa_r       <= 10'd0;
         we_r       <= 1'b0;
         hi_mask_r  <= 4'b0000;
         hi_data_r  <= 32'h0000_0000;
         two_r      <= 1'b0;
         word1_r    <= 32'h0000_0000;
`else
         misalign_r <= 1'b0;
`endif
      end else begin
         pend_r <= 1'b0;
`ifdef MISALIGNED_EN
         if (state_r == SECOND) begin
            // data_out now holds the first word of a split load.
            state_r <= IDLE;
            pend_r  <= !we_r;
            two_r   <= 1'b1;
            word1_r <= data_out;
         end else if (ok_s) begin
            off_r  <= off_s;
            f3_r   <= req_funct3;
            pend_r <= !req_we && !split_s;
            two_r  <= 1'b0;
            if (split_s) begin
               state_r   <= SECOND;
               wa_r      <= wa_s;
               we_r      <= req_we;
               hi_mask_r <= mask8_s[7:4];
               hi_data_r <= data64_s[63:32];
            end
         end
`else
         misalign_r <= bad_s;
         if (ok_s) begin
            off_r  <= off_s;
            f3_r   <= req_funct3;
            pend_r <= !req_we;
         end
`endif
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// ----------------------------------------------------------------------------
// tb_lsu_align -- directed, scoreboard-checked bench for lsu_align.
// Stimulus tasks push the expected datamem writes, load responses, stall and
// misalign pulses (with the cycle they must appear in) into queues; a monitor
// on the falling edge pops and compares whatever the DUT presents.
// Follows the MISALIGNED_EN build option of the design.
// ----------------------------------------------------------------------------
module tb_lsu_align;

   logic        clk = 1'b0;
   logic        nrst;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        misalign;
   logic [3:0]  dm_write;
   logic [9:0]  data_addr;
   logic [31:0] data_in;
   logic [31:0] data_out;

   logic [31:0] mem [0:1023];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int          cyc;
      logic [9:0]  addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } wr_t;

   wr_t         wr_q[$];
   int          rsp_cyc_q[$];
   logic [31:0] rsp_dat_q[$];
   int          mis_q[$];
   int          st_q[$];

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   lsu_align dut (
      .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .misalign(misalign), .dm_write(dm_write), .data_addr(data_addr),
      .data_in(data_in), .data_out(data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // datamem model: byte-strobed write, synchronous read of the old contents.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (dm_write[i]) mem[data_addr][8*i +: 8] <= data_in[8*i +: 8];
      end
      data_out <= mem[data_addr];
   end

   function automatic logic [31:0] bmask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Monitor: compares every DUT event against the scoreboard queues.
   always @(negedge clk) begin
      if (dm_write != 4'b0000) begin
         if (wr_q.size() == 0) unexpected("unexp_write");
         else begin
            wr_t e;
            e = wr_q.pop_front();
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            chk("wr_addr", 32'(data_addr), 32'(e.addr));
            chk("wr_strobe", 32'(dm_write), 32'(e.strb));
            chk("wr_data", data_in & bmask(dm_write), e.data & bmask(e.strb));
         end
      end
      if (rsp_valid) begin
         if (rsp_cyc_q.size() == 0) unexpected("unexp_rsp");
         else begin
            chk("rsp_cycle", 32'(cyc), 32'(rsp_cyc_q.pop_front()));
            chk("rsp_data", rsp_rdata, rsp_dat_q.pop_front());
         end
      end else begin
         chk("rdata_idle", rsp_rdata, 32'h0000_0000);
      end
      if (misalign) begin
         if (mis_q.size() == 0) unexpected("unexp_misalign");
         else chk("mis_cycle", 32'(cyc), 32'(mis_q.pop_front()));
      end
      if (stall) begin
         if (st_q.size() == 0) unexpected("unexp_stall");
         else chk("stall_cycle", 32'(cyc), 32'(st_q.pop_front()));
      end
   end

   task automatic drive(input logic we, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = {20'h00000, a};
      req_wdata  = wd;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic st(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                     input logic [9:0] wa, input logic [3:0] s, input logic [31:0] d);
      wr_t e;
      drive(1'b1, f3, a, wd);
      e.cyc = cyc; e.addr = wa; e.strb = s; e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic ld(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] exp);
      drive(1'b0, f3, a, 32'h0000_0000);
      rsp_cyc_q.push_back(cyc + 1);
      rsp_dat_q.push_back(exp);
   endtask

   // Request that must produce nothing at all (illegal funct3).
   task automatic nop_req(input logic we, input logic [2:0] f3, input logic [11:0] a);
      drive(we, f3, a, 32'hFFFF_FFFF);
   endtask

`ifdef MISALIGNED_EN
   task automatic st2(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                      input logic [9:0] wa1, input logic [3:0] s1, input logic [31:0] d1,
                      input logic [9:0] wa2, input logic [3:0] s2, input logic [31:0] d2);
      wr_t e;
      drive(1'b1, f3, a, wd);
      e.cyc = cyc;     e.addr = wa1; e.strb = s1; e.data = d1;
      wr_q.push_back(e);
      e.cyc = cyc + 1; e.addr = wa2; e.strb = s2; e.data = d2;
      wr_q.push_back(e);
      st_q.push_back(cyc);
      @(posedge clk);
      #1;
   endtask

   task automatic ld2(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] exp);
      drive(1'b0, f3, a, 32'h0000_0000);
      st_q.push_back(cyc);
      rsp_cyc_q.push_back(cyc + 2);
      rsp_dat_q.push_back(exp);
      @(posedge clk);
      #1;
   endtask
`else
   task automatic bad(input logic we, input logic [2:0] f3, input logic [11:0] a);
      drive(we, f3, a, 32'h1234_5678);
      mis_q.push_back(cyc + 1);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_misalign", 32'(misalign), 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_dm_write", 32'(dm_write), 32'h0);
      #2 nrst = 1'b1;

      // Aligned stores and preload of word 3.
      st(3'b000, 12'h001, 32'hC1C1_C1C1, 10'd0, 4'b0010, 32'hC1C1_C100);
      st(3'b010, 12'h018, 32'hC1C1_C1C1, 10'd6, 4'b1111, 32'hC1C1_C1C1);
      st(3'b010, 12'h00C, 32'h80FF_7F01, 10'd3, 4'b1111, 32'h80FF_7F01);
      // Back-to-back loads, one per cycle.
      ld(LB,  12'h00F, 32'hFFFF_FF80);
      ld(LBU, 12'h00F, 32'h0000_0080);
      ld(LH,  12'h00E, 32'hFFFF_80FF);
      ld(LW,  12'h00C, 32'h80FF_7F01);
      ld(LHU, 12'h00C, 32'h0000_7F01);
      ld(LB,  12'h00D, 32'h0000_007F);
      ld(LB,  12'h001, 32'hFFFF_FFC1);
      // Half store into upper lanes, then read back.
      st(3'b001, 12'h01A, 32'h1234_ABCD, 10'd6, 4'b1100, 32'hABCD_0000);
      ld(LW,  12'h018, 32'hABCD_C1C1);
      ld(LH,  12'h01A, 32'hFFFF_ABCD);
      ld(LHU, 12'h018, 32'h0000_C1C1);
      st(3'b000, 12'h003, 32'h0000_00EE, 10'd0, 4'b1000, 32'hEE00_0000);
      ld(LB,  12'h003, 32'hFFFF_FFEE);
      // Illegal encodings: no write, no response, no fault.
      nop_req(1'b0, 3'b011, 12'h00C);
      nop_req(1'b0, 3'b111, 12'h00C);
      nop_req(1'b1, 3'b100, 12'h00C);
      nop_req(1'b1, 3'b011, 12'h00C);
      idle();
      #1;
      chk("idle_data_addr", 32'(data_addr), 32'h0);
      chk("idle_dm_write", 32'(dm_write), 32'h0);

`ifdef MISALIGNED_EN
      st2(3'b010, 12'h001, 32'hAABB_CCDD, 10'd0, 4'b1110, 32'hBBCC_DD00,
          10'd1, 4'b0001, 32'h0000_00AA);
      ld2(LW, 12'h001, 32'hAABB_CCDD);
      st(3'b010, 12'hFFC, 32'h1100_0000, 10'h3FF, 4'b1111, 32'h1100_0000);
      st(3'b010, 12'h000, 32'h0000_0022, 10'h000, 4'b1111, 32'h0000_0022);
      ld2(LH, 12'hFFF, 32'h0000_2211);
      st2(3'b001, 12'hFFF, 32'h0000_BEEF, 10'h3FF, 4'b1000, 32'hEF00_0000,
          10'h000, 4'b0001, 32'h0000_00BE);
      ld2(LHU, 12'hFFF, 32'h0000_BEEF);
      // Misaligned but not crossing: single access.
      st(3'b001, 12'h005, 32'h0000_7788, 10'd1, 4'b0110, 32'h0077_8800);
      ld(LHU, 12'h005, 32'h0000_7788);
      // Reset during the second half of a split store.
      st(3'b010, 12'h024, 32'h1234_5678, 10'd9, 4'b1111, 32'h1234_5678);
      st(3'b010, 12'h028, 32'h9ABC_DEF0, 10'd10, 4'b1111, 32'h9ABC_DEF0);
      begin
         wr_t e;
         drive(1'b1, 3'b010, 12'h026, 32'hFFFF_FFFF);
         e.cyc = cyc; e.addr = 10'd9; e.strb = 4'b1100; e.data = 32'hFFFF_0000;
         wr_q.push_back(e);
         st_q.push_back(cyc);
      end
      @(posedge clk);
      #1 nrst = 1'b0;
      #1;
      chk("second_rst_dm_write", 32'(dm_write), 32'h0);
      chk("second_rst_stall", 32'(stall), 32'h0);
      req_valid = 1'b0;
      @(posedge clk);
      #3 nrst = 1'b1;
      ld(LW, 12'h028, 32'h9ABC_DEF0);
      ld(LW, 12'h024, 32'hFFFF_5678);
`else
      // Not naturally aligned: dropped and flagged one cycle later.
      bad(1'b0, LW, 12'h002);
      bad(1'b1, 3'b001, 12'h003);
      bad(1'b0, LH, 12'h001);
      ld(LBU, 12'h003, 32'h0000_00EE);
      bad(1'b1, 3'b010, 12'h00D);
      ld(LW, 12'h00C, 32'h80FF_7F01);
`endif

      // Reset while a store is presented: the write must not happen.
      st(3'b010, 12'h020, 32'h55AA_55AA, 10'd8, 4'b1111, 32'h55AA_55AA);
      idle();
      drive(1'b1, 3'b010, 12'h020, 32'hDEAD_BEEF);
      #1 nrst = 1'b0;
      #1;
      chk("rst_store_dm_write", 32'(dm_write), 32'h0);
      req_valid = 1'b0;
      @(posedge clk);
      #3 nrst = 1'b1;
      ld(LW, 12'h020, 32'h55AA_55AA);
      // Reset while a load response is pending: no response.
      idle();
      drive(1'b0, LW, 12'h00C, 32'h0);
      @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      chk("rst_pend_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_pend_rdata", rsp_rdata, 32'h0);
      req_valid = 1'b0;
      @(posedge clk);
      #3 nrst = 1'b1;
      ld(LW, 12'h018, 32'hABCD_C1C1);
      idle();

      repeat (4) @(posedge clk);
      #1;
      chk("wr_q_left", 32'(wr_q.size()), 32'h0);
      chk("rsp_q_left", 32'(rsp_cyc_q.size()), 32'h0);
      chk("mis_q_left", 32'(mis_q.size()), 32'h0);
      chk("stall_q_left", 32'(st_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
